fir_sample_sched: RTL and testbench

Controller for the 10-tap transposed-form FIR MAC datapath. Runs in the 12 MHz domain and:
- divides the clock down to the 300 kHz sample strobe;
- buffers one upstream 3-bit sample behind a valid/ready handshake;
- presents that sample to the MAC;
- owns the coefficient bank, with shadow/active double buffering so updates are atomic.

It also sequences start, run and flush of the filter, and qualifies the MAC output with a valid pulse.

---
 rtl/fir_sample_sched_if.sv | 22 ++
 rtl/fir_sample_sched.sv | 148 ++++++++++++++
 tb/tb_fir_sample_sched.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_sample_sched_if.sv
// Upstream sample handshake and coefficient write port of the FIR sample scheduler.
interface fir_sample_sched_if #(
  parameter int CW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [2:0]    in_data;
  logic                 coeff_wr_en;
  logic [3:0]           coeff_addr;
  logic signed [CW-1:0] coeff_data;
  logic                 coeff_commit;

  modport master (
    output in_valid, in_data, coeff_wr_en, coeff_addr, coeff_data, coeff_commit,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, coeff_wr_en, coeff_addr, coeff_data, coeff_commit,
    output in_ready
  );
endinterface

// File: rtl/fir_sample_sched.sv
// Sample-rate scheduler for the transposed-form FIR MAC: strobe divider, one-deep
// input buffer, start/run/flush sequencing and a double-buffered coefficient bank.
module fir_sample_sched #(
  parameter int DIV  = 40,
  parameter int TAPS = 10,
  parameter int CW   = 16
) (
  input  logic                 iClk_12M,
  input  logic                 iRst,
  input  logic                 iStart,
  input  logic                 iStop,
  fir_sample_sched_if.slave    bus,
  output logic signed [2:0]    oFirIn,
  output logic                 oEnSample_300k,
  output logic [TAPS*CW-1:0]   oCoeffBus,
  output logic                 oOutValid,
  output logic                 oBusy,
  output logic                 oUnderflow,
  output logic                 oCommitPend
);

  localparam int CNT_W   = $clog2(DIV);
  localparam int FILL_W  = $clog2(TAPS + 2);
  localparam int FLUSH_W = $clog2(TAPS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [FILL_W-1:0]    fill;
  logic [FLUSH_W-1:0]   flush_cnt;
  logic                 hold_valid;
  logic signed [2:0]    hold_data;
  logic                 tick;
  logic                 xfer;
  logic                 wr_ok;
  logic                 copy_now;
  logic signed [CW-1:0] shadow [TAPS];
  logic signed [CW-1:0] active [TAPS];

  // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
  always_ff @(posedge iClk_12M) begin
    if (iRst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (iStart) state_nx = S_RUN;
      S_RUN:   if (iStop)  state_nx = S_FLUSH;
      S_FLUSH: if (oEnSample_300k && flush_cnt == FLUSH_W'(TAPS)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    oBusy        = 1'b0;
    bus.in_ready = 1'b0;
    unique case (state)
      S_RUN: begin
        oBusy        = 1'b1;
        bus.in_ready = !hold_valid;
      end
      S_FLUSH: oBusy = 1'b1;
      default: ;
    endcase
  end

  assign tick     = oBusy && (cnt == CNT_W'(DIV - 1));
  assign xfer     = bus.in_valid && bus.in_ready;
  assign wr_ok    = bus.coeff_wr_en && (int'(bus.coeff_addr) < TAPS);
  // A same-cycle write+commit postpones the copy so the bank picks up that write.
  assign copy_now = oCommitPend && (state == S_IDLE || tick) && !(bus.coeff_commit && wr_ok);

  // The divider parks at 0 in IDLE and on the edge that returns to IDLE.
  always_ff @(posedge iClk_12M) begin
    if (iRst || state == S_IDLE || state_nx == S_IDLE) cnt <= '0;
    else if (tick)                                     cnt <= '0;
    else                                               cnt <= cnt + 1'b1;
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      oEnSample_300k <= 1'b0;
      oOutValid      <= 1'b0;
      oFirIn         <= '0;
      oUnderflow     <= 1'b0;
      hold_valid     <= 1'b0;
      hold_data      <= '0;
      fill           <= '0;
      flush_cnt      <= '0;
    end else begin
      oEnSample_300k <= tick;
      oOutValid      <= oEnSample_300k && (fill == FILL_W'(TAPS + 1));

      if (tick) oFirIn <= (state == S_RUN && hold_valid) ? hold_data : 3'sd0;

      if (state == S_IDLE && iStart) begin
        oUnderflow <= 1'b0;
        fill       <= '0;
      end else begin
        if (tick && state == S_RUN && !hold_valid) oUnderflow <= 1'b1;
        if (tick && fill != FILL_W'(TAPS + 1))     fill <= fill + 1'b1;
      end

      // A sample accepted in a tick cycle is held for the following tick.
      if (state != S_RUN || iStop) begin
        hold_valid <= 1'b0;
      end else if (xfer) begin
        hold_valid <= 1'b1;
        hold_data  <= bus.in_data;
      end else if (tick) begin
        hold_valid <= 1'b0;
      end

      if (state != S_FLUSH) flush_cnt <= '0;
      else if (tick)        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      // NOTE: both banks drive a primary output that must read 0 after reset, so they are reset flops, not RAM.
      for (int k = 0; k < TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      oCommitPend <= 1'b0;
    end else begin
      if (wr_ok)    shadow[bus.coeff_addr] <= bus.coeff_data;
      if (copy_now) active <= shadow;
      oCommitPend <= copy_now ? 1'b0 : (oCommitPend || bus.coeff_commit);
    end
  end

  always_comb begin
    oCoeffBus = '0;
    for (int k = 0; k < TAPS; k++) oCoeffBus[k*CW +: CW] = active[k];
  end

endmodule

// File: tb/tb_fir_sample_sched.sv
// Directed bench for fir_sample_sched: strobe timing, underflow, flush length,
// coefficient commit timing and mid-run reset, with hand-derived expectations.
module tb_fir_sample_sched;
  localparam int DIV  = 40;
  localparam int TAPS = 10;
  localparam int CW   = 16;
  localparam int BW   = TAPS * CW;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic signed [2:0] fir;
  logic              en;
  logic [BW-1:0]     cbus;
  logic              ov;
  logic              busy;
  logic              unf;
  logic              pend;

  fir_sample_sched_if #(.CW(CW)) bus ();

  fir_sample_sched #(.DIV(DIV), .TAPS(TAPS), .CW(CW)) dut (
    .iClk_12M       (clk),
    .iRst           (rst),
    .iStart         (start),
    .iStop          (stop),
    .bus            (bus),
    .oFirIn         (fir),
    .oEnSample_300k (en),
    .oCoeffBus      (cbus),
    .oOutValid      (ov),
    .oBusy          (busy),
    .oUnderflow     (unf),
    .oCommitPend    (pend)
  );

  always #5 clk = ~clk;

  int            n_checks   = 0;
  int            n_errors   = 0;
  int            fill_model = 0;
  int            extra;
  logic [BW-1:0] exp_bus    = '0;

  localparam logic signed [2:0] S_ONE  = 3'sd1;
  localparam logic signed [2:0] S_NEG2 = -3'sd2;
  localparam logic signed [2:0] S_ZERO = 3'sd0;

  task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fill_model = 0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // Waits (bounded) for the next strobe cycle and checks its spacing and sample.
  task automatic step_strobe(input string tag, input int exp_gap, input logic signed [2:0] exp_fir);
    int n = 0;
    while (!en && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, " en"}, en, 1'b1);
    check({tag, " gap"}, n, exp_gap);
    check({tag, " fir"}, fir, exp_fir);
    if (fill_model < TAPS + 1) fill_model++;
  endtask

  task automatic after_strobe(input string tag);
    @(negedge clk);
    check({tag, " ov"}, ov, fill_model >= TAPS + 1);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " fir"},   fir, 3'sd0);
    check({tag, " en"},    en, 1'b0);
    check({tag, " cbus"},  cbus, '0);
    check({tag, " ov"},    ov, 1'b0);
    check({tag, " busy"},  busy, 1'b0);
    check({tag, " unf"},   unf, 1'b0);
    check({tag, " pend"},  pend, 1'b0);
    check({tag, " ready"}, bus.in_ready, 1'b0);
  endtask

  task automatic count_stray_strobes(input string tag);
    extra = 0;
    repeat (100) begin
      @(negedge clk);
      if (en) extra++;
    end
    check({tag, " stray strobes"}, extra, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.coeff_wr_en = 1'b0; bus.coeff_addr = '0; bus.coeff_data = '0; bus.coeff_commit = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;

    // Continuous supply of +1: first strobe 40 cycles after start, then every 40.
    bus.in_valid = 1'b1;
    bus.in_data  = S_ONE;
    pulse_start();
    step_strobe("t1 s1", 40, S_ONE);
    after_strobe("t1 s1");
    for (int i = 2; i <= 11; i++) begin
      step_strobe($sformatf("t1 s%0d", i), DIV - 1, S_ONE);
      after_strobe($sformatf("t1 s%0d", i));
    end
    step_strobe("t1 s12", DIV - 1, S_ONE);
    check("t1 unf", unf, 1'b0);
    check("t1 busy", busy, 1'b1);

    // Starve one sample period.
    bus.in_valid = 1'b0;
    after_strobe("t1 s12");
    step_strobe("t2 under", DIV - 1, S_ZERO);
    check("t2 unf set", unf, 1'b1);
    bus.in_valid = 1'b1;
    after_strobe("t2 under");
    step_strobe("t2 resume", DIV - 1, S_ONE);
    check("t2 unf sticky", unf, 1'b1);
    after_strobe("t2 resume");

    // Stop with a sample held: exactly TAPS zero strobes, then IDLE.
    pulse_stop();
    check("t3 busy", busy, 1'b1);
    check("t3 ready", bus.in_ready, 1'b0);
    for (int j = 1; j <= TAPS; j++) begin
      step_strobe($sformatf("t3 f%0d", j), (j == 1) ? DIV - 2 : DIV - 1, S_ZERO);
      after_strobe($sformatf("t3 f%0d", j));
      check($sformatf("t3 f%0d busy", j), busy, j < TAPS);
    end
    count_stray_strobes("t3");

    // Coefficient load and commit in IDLE.
    for (int k = 0; k < TAPS; k++) begin
      bus.coeff_wr_en = 1'b1;
      bus.coeff_addr  = 4'(k);
      bus.coeff_data  = 16'(k + 1);
      exp_bus[k*CW +: CW] = 16'(k + 1);
      @(negedge clk);
    end
    bus.coeff_wr_en = 1'b0;
    check("t4 before commit", cbus, '0);
    bus.coeff_commit = 1'b1;
    @(negedge clk);
    bus.coeff_commit = 1'b0;
    check("t4 pend", pend, 1'b1);
    check("t4 not yet", cbus, '0);
    @(negedge clk);
    check("t4 c0", cbus[15:0], 16'd1);
    check("t4 c9", cbus[159:144], 16'd10);
    check("t4 bank", cbus, exp_bus);
    check("t4 pend clr", pend, 1'b0);

    bus.coeff_wr_en = 1'b1; bus.coeff_addr = 4'd12; bus.coeff_data = 16'sh7777;
    @(negedge clk);
    bus.coeff_wr_en = 1'b0;
    bus.coeff_commit = 1'b1;
    @(negedge clk);
    bus.coeff_commit = 1'b0;
    @(negedge clk);
    check("t4 addr12", cbus, exp_bus);

    bus.coeff_wr_en = 1'b1; bus.coeff_addr = 4'd3; bus.coeff_data = 16'sh0055;
    bus.coeff_commit = 1'b1;
    exp_bus[3*CW +: CW] = 16'h0055;
    @(negedge clk);
    bus.coeff_wr_en = 1'b0; bus.coeff_commit = 1'b0;
    check("t4 wr+commit pend", pend, 1'b1);
    @(negedge clk);
    check("t4 wr+commit bank", cbus, exp_bus);

    // Commit in RUN waits for the tick edge.
    bus.in_data = S_NEG2;
    pulse_start();
    check("t5 unf clr", unf, 1'b0);
    step_strobe("t5 s1", 40, S_NEG2);
    after_strobe("t5 s1");
    bus.coeff_wr_en = 1'b1; bus.coeff_addr = 4'd0; bus.coeff_data = 16'sh1234;
    bus.coeff_commit = 1'b1;
    @(negedge clk);
    bus.coeff_wr_en = 1'b0; bus.coeff_commit = 1'b0;
    repeat (5) @(negedge clk);
    check("t5 mid pend", pend, 1'b1);
    check("t5 mid bank", cbus, exp_bus);
    repeat (32) @(negedge clk);
    check("t5 tick-cycle bank", cbus, exp_bus);
    step_strobe("t5 s2", 1, S_NEG2);
    exp_bus[15:0] = 16'h1234;
    check("t5 new bank", cbus, exp_bus);
    check("t5 pend clr", pend, 1'b0);
    after_strobe("t5 s2");

    // Stop in the tick cycle: that tick is a RUN strobe, then TAPS flush strobes.
    repeat (DIV - 2) @(negedge clk);
    pulse_stop();
    step_strobe("t6 tick", 0, S_NEG2);
    after_strobe("t6 tick");
    for (int j = 1; j <= TAPS; j++) begin
      step_strobe($sformatf("t6 f%0d", j), DIV - 1, S_ZERO);
      after_strobe($sformatf("t6 f%0d", j));
      check($sformatf("t6 f%0d busy", j), busy, j < TAPS);
    end
    count_stray_strobes("t6");

    // Reset mid-RUN with a held sample and a pending commit.
    bus.in_data = 3'sd3;
    pulse_start();
    repeat (3) @(negedge clk);
    bus.coeff_commit = 1'b1;
    @(negedge clk);
    bus.coeff_commit = 1'b0;
    check("t7 pend", pend, 1'b1);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("t7 reset");
    bus.coeff_commit = 1'b1;
    @(negedge clk);
    bus.coeff_commit = 1'b0;
    repeat (2) @(negedge clk);
    check("t7 shadow cleared", cbus, '0);
    pulse_start();
    step_strobe("t7 s1", 40, S_ZERO);
    check("t7 unf", unf, 1'b1);
    after_strobe("t7 s1");
    rst = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
